// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed op latency and reports Busy/Done.
// Optional macro MD_ABORT_EN adds the Abort port used to flush an in-flight operation.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWr,
    input  logic        LOWr,
    input  logic [31:0] WD,
`ifdef MD_ABORT_EN
    input  logic        Abort,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q,  cnt_d;
    logic [1:0]  op_q,   op_d;
    logic [31:0] a_q,    a_d;
    logic [31:0] b_q,    b_d;
    logic [31:0] hi_q,   hi_d;
    logic [31:0] lo_q,   lo_d;
    logic        done_q, done_d;

    logic        abort_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] div_b_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [63:0] prod_s;

`ifdef MD_ABORT_EN
    assign abort_s = Abort;
`else
    assign abort_s = 1'b0;
`endif

    // Result datapath from the latched operands; division works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        neg_a_s = (op_q[0] == 1'b0) && a_q[31];
        neg_b_s = (op_q[0] == 1'b0) && b_q[31];
        if (neg_a_s) begin
            mag_a_s = (~a_q) + 32'd1;
        end else begin
            mag_a_s = a_q;
        end
        if (neg_b_s) begin
            mag_b_s = (~b_q) + 32'd1;
        end else begin
            mag_b_s = b_q;
        end
        if (b_q == 32'd0) begin
            div_b_s = 32'd1;
        end else begin
            div_b_s = mag_b_s;
        end
        uquo_s = mag_a_s / div_b_s;
        urem_s = mag_a_s % div_b_s;
        if (neg_a_s ^ neg_b_s) begin
            quo_s = (~uquo_s) + 32'd1;
        end else begin
            quo_s = uquo_s;
        end
        if (neg_a_s) begin
            rem_s = (~urem_s) + 32'd1;
        end else begin
            rem_s = urem_s;
        end
        if (op_q[0] == 1'b0) begin
            prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end else begin
            prod_s = {32'd0, a_q} * {32'd0, b_q};
        end
    end

    // Sequencer next state: abort, then start/write in idle, then countdown and commit.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (abort_s) begin
            cnt_d = 4'd0;
        end else if (cnt_q == 4'd0) begin
            if (Start) begin
                op_d = Op;
                a_d  = A;
                b_d  = B;
                if (Op[1]) begin
                    cnt_d = DIV_LOAD;
                end else begin
                    cnt_d = MULT_LOAD;
                end
            end else begin
                if (HIWr) begin
                    hi_d = WD;
                end else begin
                    hi_d = hi_q;
                end
                if (LOWr) begin
                    lo_d = WD;
                end else begin
                    lo_d = lo_q;
                end
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                done_d = 1'b1;
                if (op_q[1] == 1'b0) begin
                    hi_d = prod_s[63:32];
                    lo_d = prod_s[31:0];
                end else if (b_q != 32'd0) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end else begin
                done_d = 1'b0;
            end
        end
    end

    // State and architectural registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q  <= 4'd0;
            op_q   <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = (cnt_q != 4'd0);
    assign Done = done_q;

endmodule
